switch_iq_sched: RTL and testbench
==================================

# switch_iq_sched

Frame-level crossbar scheduler for the input-queued switch. Each cycle it matches head-of-line frames waiting at the per-input FIFOs to free output ports, using a rotating-priority greedy match. It holds every connection until that frame's last beat has transferred. The crossbar datapath consumes its registered grant matrix (input→output select) and does no arbitration of its own.

## Interface
- RADIX, 4, number of switch ports
- AXIS_DEST_WIDTH, RADIX, width of per-input destination mask (bit m = output m)
- SEL_WIDTH, $clog2(RADIX) (min 1), width of per-output source index
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- req_valid  in  RADIX  input n has a head-of-line beat (FIFO m_axis_tvalid)
- req_dest  in  RADIX*AXIS_DEST_WIDTH  tdest of head-of-line beat, output bitmask
- frame_done  in  RADIX  input n transferred its tlast beat this cycle (tvalid&tready&tlast at crossbar input)
- cfg_out_en  in  RADIX  output m may receive new grants
- in_grant  out  RADIX  input n connected; crossbar may drive its tready
- in_drop  out  RADIX  input n granted with empty mask; crossbar discards frame (tready=1)
- out_valid  out  RADIX  output m connected
- out_src  out  RADIX*SEL_WIDTH  source input index for output m; valid only when out_valid[m]

## Operation
- State: per input active bit and latched mask; per output busy bit and owner index; rotating pointer ptr (SEL_WIDTH bits).
- Input n eligible in cycle t: req_valid[n] & ~active[n] & ~frame_done[n].
- Output m free in cycle t: (~busy[m] | frame_done[owner[m]]) & cfg_out_en[m]. Outputs released this cycle are re-grantable this cycle.
- Match: visit inputs ptr, ptr+1, … mod RADIX. Grant n if eligible and every bit of its effective mask is free and not claimed earlier in this pass. All-or-nothing; no partial multicast grants.
- Effective mask = req_dest (see Configuration). An empty mask is always grantable and sets in_drop[n].
- ptr ← (first granted index + 1) mod RADIX; unchanged if nothing granted.
- Mask is sampled at grant; req_dest changes during a frame are ignored. Deassertion of req_valid mid-frame does not release the grant.
- Release: frame_done[n] with active[n] clears active[n], in_drop[n] and busy on all outputs owned by n. frame_done[n] without active[n] is ignored.
- Clearing cfg_out_en[m] while busy lets the current frame finish and blocks new grants to m.
- Greedy match may starve a wide multicast mask behind unicast traffic. This is accepted.

## Timing
- Reset: in_grant, in_drop, out_valid = 0; out_src = 0; ptr = 0; all state cleared. Takes effect the cycle after rst high, including mid-frame.
- Grant latency: request eligible in cycle t → in_grant/out_valid/out_src high at t+1.
- Back-to-back: frame_done on output m's owner in cycle t, another input waiting → new owner visible at t+1, zero bubble.
- The same input's next frame is eligible no earlier than t+1 after its frame_done, so its grant appears at t+2 or later.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SWITCH_IQ_SCHED_MCAST_EN defined: req_dest used as-is; multi-bit masks are granted atomically to all named outputs.
- Not defined: effective mask is the lowest set bit of req_dest only (unicast). Multi-bit masks are reduced, not rejected. Zero mask is still a drop.

## Structure
- Shared package switch_pkg: SEL_WIDTH derivation function, mask-to-lowest-bit function, one-hot-to-index function.
- One sub-module: switch_iq_sched_match. This is the combinational rotating-priority greedy matcher (eligible, masks, free vector, ptr → grant vector, claimed outputs, next ptr). State registers live in the top.

## Test plan
- Reset: hold rst 3 cycles with req_valid=4'b1111 → all outputs 0, ptr 0; first grant appears 1 cycle after rst falls.
- Contention: inputs 0 and 1 both dest 4'b0100 at t, ptr=0 → t+1 out_valid[2]=1, out_src[2]=0. frame_done[0] at t+5 → t+6 out_src[2]=1 with out_valid continuous.
- Multicast (macro defined): input 3 owns output 1; input 2 requests 4'b0011 → no grant to output 0 or 1 for input 2; frame_done[3] at t → t+1 out_src[0]=out_src[1]=2.
- Unicast (macro undefined): input 1 dest 4'b0110 → only out_valid[1]=1, out_src[1]=1; output 2 stays free for input 0 dest 4'b0100 the same cycle.
- Drop: input 0 dest 4'b0000 → in_grant[0]=in_drop[0]=1, out_valid=0; frame_done[0] → both clear next cycle.
- Disable: cfg_out_en[3]=0, input 2 dest 4'b1000 → never granted; set cfg_out_en[3]=1 at t → grant at t+1.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared helpers for the input-queued switch scheduler: select-width
// derivation, lowest-set-bit mask reduction and one-hot to index encoding.
package switch_pkg;

    // Widest port count any helper below is asked to handle
    localparam int MAX_PORTS = 32;

    // Width of a port index, never narrower than one bit
    function automatic int sel_width(input int radix);
        if (radix > 1) begin
            return $clog2(radix);
        end else begin
            return 1;
        end
    endfunction

    // Keep only the lowest set bit of a destination mask (zero stays zero)
    function automatic logic [MAX_PORTS-1:0] lowest_bit(input logic [MAX_PORTS-1:0] mask);
        return mask & (~mask + 32'd1);
    endfunction

    // Index of the set bit in a one-hot vector (zero for an all-zero vector)
    function automatic int onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) begin
                idx = i;
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/switch_iq_sched_match.sv
// Combinational rotating-priority greedy matcher. Inputs are visited from
// i_ptr upward (wrapping); an input is granted only when every output in its
// mask is free and not yet claimed earlier in the same pass. Grants are
// all-or-nothing, and an empty mask is always grantable.
module switch_iq_sched_match
    import switch_pkg::*;
#(
    parameter int RADIX     = 4,
    parameter int SEL_WIDTH = sel_width(RADIX)
) (
    input  logic [RADIX-1:0]            i_eligible,
    input  logic [RADIX-1:0][RADIX-1:0] i_mask,
    input  logic [RADIX-1:0]            i_free,
    input  logic [SEL_WIDTH-1:0]        i_ptr,
    output logic [RADIX-1:0]            o_grant,
    output logic [RADIX-1:0]            o_claim,
    output logic [SEL_WIDTH-1:0]        o_next_ptr
);

    localparam logic [SEL_WIDTH:0] RADIX_W = (SEL_WIDTH+1)'(RADIX);

    logic [SEL_WIDTH:0]   w_sum;
    logic [SEL_WIDTH-1:0] w_idx;
    logic [RADIX-1:0]     w_claim;
    logic [RADIX-1:0]     w_first_oh;
    logic                 w_found;
    logic [SEL_WIDTH:0]   w_nsum;

    // Single greedy pass over the inputs in rotating order
    always_comb begin
        o_grant    = '0;
        w_claim    = '0;
        w_first_oh = '0;
        w_found    = 1'b0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = 0; k < RADIX; k++) begin
            w_sum = {1'b0, i_ptr} + (SEL_WIDTH+1)'(k);
            if (w_sum >= RADIX_W) begin
                w_sum = w_sum - RADIX_W;
            end else begin
                w_sum = w_sum;
            end
            w_idx = w_sum[SEL_WIDTH-1:0];
            if (i_eligible[w_idx] && ((i_mask[w_idx] & ~(i_free & ~w_claim)) == '0)) begin
                o_grant[w_idx] = 1'b1;
                w_claim        = w_claim | i_mask[w_idx];
                if (!w_found) begin
                    w_first_oh[w_idx] = 1'b1;
                    w_found           = 1'b1;
                end else begin
                    w_found = w_found;
                end
            end else begin
                w_claim = w_claim;
            end
        end
    end

    // Pointer moves just past the first input granted in this pass
    always_comb begin
        w_nsum = (SEL_WIDTH+1)'(onehot_to_idx(MAX_PORTS'(w_first_oh)))
               + {{SEL_WIDTH{1'b0}}, 1'b1};
        if (w_nsum >= RADIX_W) begin
            w_nsum = w_nsum - RADIX_W;
        end else begin
            w_nsum = w_nsum;
        end
        if (w_found) begin
            o_next_ptr = w_nsum[SEL_WIDTH-1:0];
        end else begin
            o_next_ptr = i_ptr;
        end
    end

    assign o_claim = w_claim;

endmodule

// File: rtl/switch_iq_sched.sv
// Frame-level crossbar scheduler for the input-queued switch. Matches
// head-of-line frames to free outputs every cycle and holds each connection
// until the frame's last beat. All outputs come straight from registers.
// Optional feature: define SWITCH_IQ_SCHED_MCAST_EN to grant multi-bit
// destination masks atomically; otherwise only the lowest set bit is used.
module switch_iq_sched
    import switch_pkg::*;
#(
    parameter int RADIX           = 4,
    parameter int AXIS_DEST_WIDTH = RADIX,
    parameter int SEL_WIDTH       = sel_width(RADIX)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [RADIX-1:0]                 req_valid,
    input  logic [RADIX*AXIS_DEST_WIDTH-1:0] req_dest,
    input  logic [RADIX-1:0]                 frame_done,
    input  logic [RADIX-1:0]                 cfg_out_en,
    output logic [RADIX-1:0]                 in_grant,
    output logic [RADIX-1:0]                 in_drop,
    output logic [RADIX-1:0]                 out_valid,
    output logic [RADIX*SEL_WIDTH-1:0]       out_src
);

    // Per-input connection state
    logic [RADIX-1:0]                r_active;
    logic [RADIX-1:0]                r_drop;
    logic [RADIX-1:0][RADIX-1:0]     r_mask;
    // Per-output connection state
    logic [RADIX-1:0]                r_busy;
    logic [RADIX-1:0][SEL_WIDTH-1:0] r_owner;
    logic [SEL_WIDTH-1:0]            r_ptr;

    logic [RADIX-1:0][RADIX-1:0]     w_eff;
    logic [RADIX-1:0]                w_elig;
    logic [RADIX-1:0]                w_rel_in;
    logic [RADIX-1:0]                w_rel_out;
    logic [RADIX-1:0]                w_free;
    logic [RADIX-1:0]                w_grant;
    logic [RADIX-1:0]                w_claim;
    logic [SEL_WIDTH-1:0]            w_next_ptr;
    logic [RADIX-1:0][SEL_WIDTH-1:0] w_new_src;

    // Effective destination mask of each head-of-line frame
    always_comb begin
        w_eff = '0;
        for (int n = 0; n < RADIX; n++) begin
`ifdef SWITCH_IQ_SCHED_MCAST_EN
            w_eff[n] = req_dest[n*AXIS_DEST_WIDTH +: RADIX];
`else
            w_eff[n] = RADIX'(lowest_bit(MAX_PORTS'(req_dest[n*AXIS_DEST_WIDTH +: RADIX])));
`endif
        end
    end

    // A frame only finishes on an input that actually holds a connection
    assign w_rel_in = frame_done & r_active;
    // An input whose frame ends this cycle must wait a cycle before re-requesting
    assign w_elig   = req_valid & ~r_active & ~frame_done;

    // Outputs released this cycle by their owners' final beat
    always_comb begin
        w_rel_out = '0;
        for (int n = 0; n < RADIX; n++) begin
            if (w_rel_in[n]) begin
                w_rel_out = w_rel_out | r_mask[n];
            end else begin
                w_rel_out = w_rel_out;
            end
        end
    end

    // Released outputs are immediately re-grantable; disabled ones never are
    assign w_free = (~r_busy | w_rel_out) & cfg_out_en;

    switch_iq_sched_match #(
        .RADIX     (RADIX),
        .SEL_WIDTH (SEL_WIDTH)
    ) u_match (
        .i_eligible (w_elig),
        .i_mask     (w_eff),
        .i_free     (w_free),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_claim    (w_claim),
        .o_next_ptr (w_next_ptr)
    );

    // Source index for every output claimed in this pass
    always_comb begin
        w_new_src = '0;
        for (int m = 0; m < RADIX; m++) begin
            for (int n = 0; n < RADIX; n++) begin
                if (w_grant[n] && w_eff[n][m]) begin
                    w_new_src[m] = SEL_WIDTH'(n);
                end else begin
                    w_new_src[m] = w_new_src[m];
                end
            end
        end
    end

    // Connection state: grants set, final beats clear, reset wipes everything
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active <= '0;
            r_drop   <= '0;
            r_mask   <= '0;
            r_busy   <= '0;
            r_owner  <= '0;
            r_ptr    <= '0;
        end else begin
            r_ptr <= w_next_ptr;
            for (int n = 0; n < RADIX; n++) begin
                if (w_grant[n]) begin
                    r_active[n] <= 1'b1;
                    r_mask[n]   <= w_eff[n];
                    r_drop[n]   <= (w_eff[n] == '0);
                end else if (w_rel_in[n]) begin
                    r_active[n] <= 1'b0;
                    r_mask[n]   <= '0;
                    r_drop[n]   <= 1'b0;
                end else begin
                    r_active[n] <= r_active[n];
                end
            end
            for (int m = 0; m < RADIX; m++) begin
                if (w_claim[m]) begin
                    r_busy[m]  <= 1'b1;
                    r_owner[m] <= w_new_src[m];
                end else if (w_rel_out[m]) begin
                    r_busy[m]  <= 1'b0;
                end else begin
                    r_busy[m]  <= r_busy[m];
                end
            end
        end
    end

    assign in_grant  = r_active;
    assign in_drop   = r_drop;
    assign out_valid = r_busy;
    assign out_src   = r_owner;

endmodule

// File: tb/tb_switch_iq_sched.sv
// Self-checking bench for switch_iq_sched: directed scenarios plus a random
// run compared against a frame-level reference model of the scheduler.
module tb_switch_iq_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_dest;
    logic [3:0]  frame_done;
    logic [3:0]  cfg_out_en;
    logic [3:0]  in_grant;
    logic [3:0]  in_drop;
    logic [3:0]  out_valid;
    logic [7:0]  out_src;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: owner of each output (-1 = idle), per-input flags
    int m_active[4];
    int m_drop[4];
    int m_owner[4];
    int m_ptr;

    switch_iq_sched dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_dest   (req_dest),
        .frame_done (frame_done),
        .cfg_out_en (cfg_out_en),
        .in_grant   (in_grant),
        .in_drop    (in_drop),
        .out_valid  (out_valid),
        .out_src    (out_src)
    );

    always #5 clk = ~clk;

    // Advance the model by one cycle using the inputs currently driven
    task automatic model_step();
        int  eff[4];
        bit  elig[4];
        bit  freev[4];
        bit  granted[4];
        int  claimed;
        int  first;
        int  n;
        bit  ok;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_active[i] = 0;
                m_drop[i]   = 0;
                m_owner[i]  = -1;
            end
            m_ptr = 0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            eff[i] = int'(req_dest[i*4 +: 4]);
`ifndef SWITCH_IQ_SCHED_MCAST_EN
            eff[i] = eff[i] & (-eff[i]);
`endif
            elig[i]    = req_valid[i] && (m_active[i] == 0) && !frame_done[i];
            freev[i]   = cfg_out_en[i] && ((m_owner[i] < 0) || frame_done[m_owner[i]]);
            granted[i] = 1'b0;
        end
        claimed = 0;
        first   = -1;
        for (int k = 0; k < 4; k++) begin
            n = (m_ptr + k) % 4;
            if (elig[n]) begin
                ok = 1'b1;
                for (int m = 0; m < 4; m++) begin
                    if (((eff[n] >> m) & 1) != 0 && (!freev[m] || ((claimed >> m) & 1) != 0))
                        ok = 1'b0;
                end
                if (ok) begin
                    granted[n] = 1'b1;
                    claimed    = claimed | eff[n];
                    if (first < 0) first = n;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (frame_done[i] && m_active[i] != 0) begin
                m_active[i] = 0;
                m_drop[i]   = 0;
                for (int m = 0; m < 4; m++)
                    if (m_owner[m] == i) m_owner[m] = -1;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (granted[i]) begin
                m_active[i] = 1;
                m_drop[i]   = (eff[i] == 0) ? 1 : 0;
                for (int m = 0; m < 4; m++)
                    if (((eff[i] >> m) & 1) != 0) m_owner[m] = i;
            end
        end
        if (first >= 0) m_ptr = (first + 1) % 4;
    endtask

    // One clock cycle: model update, active edge, then settle to the falling edge
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_dest   = 16'h0000;
        frame_done = 4'b0000;
        cfg_out_en = 4'b1111;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = 4'b1111;
        req_dest   = 16'h8421;
        frame_done = 4'b0000;
        cfg_out_en = 4'b1111;
        for (int i = 0; i < 3; i++) tick();
        n_tests++; if (in_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_in_grant: got %b want %b", in_grant, 4'b0000); end
        n_tests++; if (in_drop !== 4'b0000) begin n_fail++; $display("FAIL reset_in_drop: got %b want %b", in_drop, 4'b0000); end
        n_tests++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_out_valid: got %b want %b", out_valid, 4'b0000); end
        n_tests++; if (out_src !== 8'h00) begin n_fail++; $display("FAIL reset_out_src: got %h want %h", out_src, 8'h00); end
        rst = 1'b0;
        tick();
        n_tests++; if (in_grant !== 4'b1111) begin n_fail++; $display("FAIL reset_first_grant: got %b want %b", in_grant, 4'b1111); end
        n_tests++; if (out_src !== 8'b11100100) begin n_fail++; $display("FAIL reset_first_src: got %b want %b", out_src, 8'b11100100); end
        req_valid  = 4'b0000;
        frame_done = 4'b1111;
        tick();
        frame_done = 4'b0000;
        n_tests++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_release_all: got %b want %b", out_valid, 4'b0000); end
    endtask

    task automatic test_contention();
        do_reset();
        req_valid        = 4'b0011;
        req_dest         = 16'h0000;
        req_dest[3:0]    = 4'b0100;
        req_dest[7:4]    = 4'b0100;
        tick();
        n_tests++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL cont_out_valid: got %b want %b", out_valid, 4'b0100); end
        n_tests++; if (out_src[5:4] !== 2'd0) begin n_fail++; $display("FAIL cont_src_first: got %0d want %0d", out_src[5:4], 0); end
        n_tests++; if (in_grant !== 4'b0001) begin n_fail++; $display("FAIL cont_in_grant: got %b want %b", in_grant, 4'b0001); end
        for (int i = 0; i < 4; i++) tick();
        frame_done = 4'b0001;
        tick();
        frame_done = 4'b0000;
        n_tests++; if (out_valid !== 4'b0100) begin n_fail++; $display("FAIL cont_no_bubble: got %b want %b", out_valid, 4'b0100); end
        n_tests++; if (out_src[5:4] !== 2'd1) begin n_fail++; $display("FAIL cont_src_next: got %0d want %0d", out_src[5:4], 1); end
        tick();
        n_tests++; if (in_grant !== 4'b0010) begin n_fail++; $display("FAIL cont_hold: got %b want %b", in_grant, 4'b0010); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_valid     = 4'b0001;
        req_dest      = 16'h0000;
        req_dest[3:0] = 4'b0001;
        tick();
        frame_done = 4'b0001;
        tick();
        frame_done = 4'b0000;
        n_tests++; if (in_grant !== 4'b0000) begin n_fail++; $display("FAIL b2b_gap: got %b want %b", in_grant, 4'b0000); end
        tick();
        n_tests++; if (in_grant !== 4'b0001) begin n_fail++; $display("FAIL b2b_regrant: got %b want %b", in_grant, 4'b0001); end
    endtask

    task automatic test_cast();
        do_reset();
`ifdef SWITCH_IQ_SCHED_MCAST_EN
        req_valid       = 4'b1000;
        req_dest        = 16'h0000;
        req_dest[15:12] = 4'b0010;
        tick();
        n_tests++; if (out_src[3:2] !== 2'd3) begin n_fail++; $display("FAIL mcast_owner3: got %0d want %0d", out_src[3:2], 3); end
        req_valid      = 4'b1100;
        req_dest[11:8] = 4'b0011;
        tick();
        n_tests++; if (in_grant !== 4'b1000) begin n_fail++; $display("FAIL mcast_blocked: got %b want %b", in_grant, 4'b1000); end
        n_tests++; if (out_valid !== 4'b0010) begin n_fail++; $display("FAIL mcast_no_partial: got %b want %b", out_valid, 4'b0010); end
        frame_done = 4'b1000;
        req_valid  = 4'b0100;
        tick();
        frame_done = 4'b0000;
        n_tests++; if (out_valid !== 4'b0011) begin n_fail++; $display("FAIL mcast_valid: got %b want %b", out_valid, 4'b0011); end
        n_tests++; if (out_src[3:0] !== 4'b1010) begin n_fail++; $display("FAIL mcast_src: got %b want %b", out_src[3:0], 4'b1010); end
`else
        req_valid     = 4'b0011;
        req_dest      = 16'h0000;
        req_dest[3:0] = 4'b0100;
        req_dest[7:4] = 4'b0110;
        tick();
        n_tests++; if (out_valid !== 4'b0110) begin n_fail++; $display("FAIL ucast_valid: got %b want %b", out_valid, 4'b0110); end
        n_tests++; if (out_src[3:2] !== 2'd1) begin n_fail++; $display("FAIL ucast_src1: got %0d want %0d", out_src[3:2], 1); end
        n_tests++; if (out_src[5:4] !== 2'd0) begin n_fail++; $display("FAIL ucast_src2: got %0d want %0d", out_src[5:4], 0); end
        n_tests++; if (in_grant !== 4'b0011) begin n_fail++; $display("FAIL ucast_grant: got %b want %b", in_grant, 4'b0011); end
`endif
    endtask

    task automatic test_drop();
        do_reset();
        req_valid = 4'b0001;
        req_dest  = 16'h0000;
        tick();
        n_tests++; if (in_grant !== 4'b0001) begin n_fail++; $display("FAIL drop_grant: got %b want %b", in_grant, 4'b0001); end
        n_tests++; if (in_drop !== 4'b0001) begin n_fail++; $display("FAIL drop_flag: got %b want %b", in_drop, 4'b0001); end
        n_tests++; if (out_valid !== 4'b0000) begin n_fail++; $display("FAIL drop_no_out: got %b want %b", out_valid, 4'b0000); end
        req_valid  = 4'b0000;
        frame_done = 4'b0001;
        tick();
        frame_done = 4'b0000;
        n_tests++; if ({in_grant, in_drop} !== 8'h00) begin n_fail++; $display("FAIL drop_clear: got %b want %b", {in_grant, in_drop}, 8'h00); end
    endtask

    task automatic test_disable();
        do_reset();
        cfg_out_en      = 4'b0111;
        req_valid       = 4'b0100;
        req_dest        = 16'h0000;
        req_dest[11:8]  = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++; if (in_grant !== 4'b0000) begin n_fail++; $display("FAIL dis_blocked: got %b want %b", in_grant, 4'b0000); end
        end
        cfg_out_en = 4'b1111;
        tick();
        n_tests++; if (out_valid !== 4'b1000) begin n_fail++; $display("FAIL dis_enable_valid: got %b want %b", out_valid, 4'b1000); end
        n_tests++; if (out_src[7:6] !== 2'd2) begin n_fail++; $display("FAIL dis_enable_src: got %0d want %0d", out_src[7:6], 2); end
        cfg_out_en = 4'b0111;
        tick();
        n_tests++; if (out_valid !== 4'b1000) begin n_fail++; $display("FAIL dis_finish_frame: got %b want %b", out_valid, 4'b1000); end
        frame_done = 4'b0100;
        tick();
        frame_done = 4'b0000;
        tick();
        n_tests++; if (in_grant !== 4'b0000) begin n_fail++; $display("FAIL dis_no_regrant: got %b want %b", in_grant, 4'b0000); end
        cfg_out_en = 4'b1111;
    endtask

    task automatic test_random();
        logic [3:0] eg, ed, ev;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            req_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                req_dest[i*4 +: 4] = 4'($urandom_range(0, 15));
                frame_done[i]      = ($urandom_range(0, 3) == 0);
                cfg_out_en[i]      = ($urandom_range(0, 7) != 0);
            end
            tick();
            for (int i = 0; i < 4; i++) begin
                eg[i] = (m_active[i] != 0);
                ed[i] = (m_drop[i] != 0);
                ev[i] = (m_owner[i] >= 0);
            end
            n_tests++; if (in_grant !== eg) begin n_fail++; $display("FAIL rand_in_grant c=%0d: got %b want %b", c, in_grant, eg); end
            n_tests++; if (in_drop !== ed) begin n_fail++; $display("FAIL rand_in_drop c=%0d: got %b want %b", c, in_drop, ed); end
            n_tests++; if (out_valid !== ev) begin n_fail++; $display("FAIL rand_out_valid c=%0d: got %b want %b", c, out_valid, ev); end
            for (int m = 0; m < 4; m++) begin
                if (m_owner[m] >= 0) begin
                    n_tests++;
                    if (int'(out_src[m*2 +: 2]) != m_owner[m]) begin
                        n_fail++;
                        $display("FAIL rand_out_src c=%0d m=%0d: got %0d want %0d", c, m, out_src[m*2 +: 2], m_owner[m]);
                    end
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 4'b0000;
        req_dest   = 16'h0000;
        frame_done = 4'b0000;
        cfg_out_en = 4'b1111;
        test_reset();
        test_contention();
        test_back_to_back();
        test_cast();
        test_drop();
        test_disable();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
